// File: rtl/ac97_cmd_scheduler.sv
// ac97_cmd_scheduler
//   Chooses the slot-1/2 command carried by each AC97 output frame. After
//   reset it walks a fixed codec init table, one write per frame. It then
//   serves CPU register reads and writes. In the volume-tracking build it
//   also inserts periodic and on-change master/headphone volume refreshes.
//
// Optional feature: define AC97_VOL_TRACK_EN to enable volume tracking and
//   periodic refresh. With the macro undefined, the volume is written only
//   by the init table and the REFRESH state is never entered.
//
// Handshake: cpu_req_valid is asserted by the CPU, with the request fields
//   held stable, until it sees cpu_req_ready. cpu_req_ready is a
//   combinational one-cycle pulse that fires only in the frame_req cycle
//   that picks the CPU.
//
// Ports
//   bit_clk, reset_b          clock, async active-low reset
//   frame_req                 per-frame decision strobe from the frame engine
//   cmd_valid/read/addr/data  command for the current frame (updated 1 cycle
//                             after frame_req, held until the next one)
//   cpu_req_*                 CPU register request channel
//   status_valid/addr/data    decoded codec slot-1/2 status
//   rd_resp_valid/data/err    read response pulse (err=1 on timeout, data=FFFFh)
//   volume_control            4-bit attenuation switch
//   init_done                 init table fully issued
//   dbg_state                 current FSM state (INIT=0, IDLE=1, RD_WAIT=2, REFRESH=3)
module ac97_cmd_scheduler #(
  parameter int INIT_LEN          = 6,
  parameter int REFRESH_FRAMES    = 64,
  parameter int RD_TIMEOUT_FRAMES = 4
) (
  input  logic        bit_clk,
  input  logic        reset_b,
  input  logic        frame_req,
  output logic        cmd_valid,
  output logic        cmd_read,
  output logic [6:0]  cmd_addr,
  output logic [15:0] cmd_data,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_rd,
  input  logic [6:0]  cpu_req_addr,
  input  logic [15:0] cpu_req_data,
  output logic        cpu_req_ready,
  input  logic        status_valid,
  input  logic [6:0]  status_addr,
  input  logic [15:0] status_data,
  output logic        rd_resp_valid,
  output logic [15:0] rd_resp_data,
  output logic        rd_resp_err,
  input  logic [3:0]  volume_control,
  output logic        init_done,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int TO_W  = (RD_TIMEOUT_FRAMES > 1) ? $clog2(RD_TIMEOUT_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_RD_WAIT = 2'd2,
    S_REFRESH = 2'd3
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_init_idx;
  logic [TO_W-1:0]   r_to_cnt;
  logic [6:0]        r_rd_addr;
  logic              r_cmd_valid;
  logic              r_cmd_read;
  logic [6:0]        r_cmd_addr;
  logic [15:0]       r_cmd_data;
  logic              r_rd_resp_valid;
  logic [15:0]       r_rd_resp_data;
  logic              r_rd_resp_err;
  logic              r_init_done;

  logic [15:0]       w_vol;
  logic              w_refresh_pend;
  logic              w_cpu_accept;
  logic              w_match;

  // Volume word layout shared by registers 02h and 04h: the same
  // attenuation goes to both channels, and the mute bits stay clear.
  assign w_vol = {3'b000, 1'b1, volume_control, 3'b000, 1'b1, volume_control};

  assign w_cpu_accept = frame_req && (r_state == S_IDLE) && !w_refresh_pend && cpu_req_valid;
  assign w_match      = status_valid && (status_addr == r_rd_addr);

  // Init table entry {addr, data}; the volume entries use the live value.
  function automatic logic [22:0] init_entry(input logic [IDX_W-1:0] idx, input logic [15:0] vol);
    logic [22:0] e;
    case (int'(idx))
      0:       e = {7'h02, vol};
      1:       e = {7'h04, vol};
      2:       e = {7'h18, 16'h0808};
      3:       e = {7'h0E, 16'h0008};
      4:       e = {7'h1A, 16'h0000};
      5:       e = {7'h1C, 16'h0000};
      default: e = {7'h00, 16'h0000};
    endcase
    return e;
  endfunction

`ifdef AC97_VOL_TRACK_EN
  localparam int REF_W = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;

  logic [REF_W-1:0] r_ref_cnt;
  logic [3:0]       r_vc_q;
  logic             r_refresh_pend;
  logic             w_ref_wrap;
  logic             w_vol_chg;
  logic             w_refresh_take;

  assign w_ref_wrap = frame_req && (r_state != S_INIT) &&
                      (r_ref_cnt == REF_W'(REFRESH_FRAMES - 1));
  // Before the first init write nothing has been sent yet, so a difference
  // from the reset value of r_vc_q is not a real change.
  assign w_vol_chg = (volume_control != r_vc_q) &&
                     !((r_state == S_INIT) && (r_init_idx == '0));
  assign w_refresh_take = frame_req && (r_state == S_IDLE) && r_refresh_pend;
  assign w_refresh_pend = r_refresh_pend;

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_ref_cnt      <= '0;
      r_vc_q         <= 4'h0;
      r_refresh_pend <= 1'b0;
    end else begin
      r_vc_q <= volume_control;
      if (frame_req && (r_state != S_INIT))
        r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + REF_W'(1);
      // Triggers arriving while a refresh is pending merge into it. A new
      // trigger in the take cycle wins, so the latest volume is always sent.
      if (w_ref_wrap || w_vol_chg)
        r_refresh_pend <= 1'b1;
      else if (w_refresh_take)
        r_refresh_pend <= 1'b0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg   = (REFRESH_FRAMES > 0);
  assign w_refresh_pend = 1'b0;
`endif

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state         <= S_INIT;
      r_init_idx      <= '0;
      r_to_cnt        <= '0;
      r_rd_addr       <= 7'h00;
      r_cmd_valid     <= 1'b0;
      r_cmd_read      <= 1'b0;
      r_cmd_addr      <= 7'h00;
      r_cmd_data      <= 16'h0000;
      r_rd_resp_valid <= 1'b0;
      r_rd_resp_data  <= 16'h0000;
      r_rd_resp_err   <= 1'b0;
      r_init_done     <= 1'b0;
    end else begin
      r_rd_resp_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (frame_req) begin
            {r_cmd_addr, r_cmd_data} <= init_entry(r_init_idx, w_vol);
            r_cmd_valid <= 1'b1;
            r_cmd_read  <= 1'b0;
            if (r_init_idx == IDX_W'(INIT_LEN - 1)) begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_init_idx <= r_init_idx + IDX_W'(1);
            end
          end
        end
        S_IDLE: begin
          if (frame_req) begin
            if (w_refresh_pend) begin
              r_cmd_valid <= 1'b1;
              r_cmd_read  <= 1'b0;
              r_cmd_addr  <= 7'h02;
              r_cmd_data  <= w_vol;
              r_state     <= S_REFRESH;
            end else if (w_cpu_accept) begin
              r_cmd_valid <= 1'b1;
              r_cmd_read  <= cpu_req_rd;
              r_cmd_addr  <= cpu_req_addr;
              r_cmd_data  <= cpu_req_rd ? 16'h0000 : cpu_req_data;
              if (cpu_req_rd) begin
                r_rd_addr <= cpu_req_addr;
                r_to_cnt  <= '0;
                r_state   <= S_RD_WAIT;
              end
            end else begin
              r_cmd_valid <= 1'b0;
              r_cmd_read  <= 1'b0;
              r_cmd_addr  <= 7'h00;
              r_cmd_data  <= 16'h0000;
            end
          end
        end
        S_REFRESH: begin
          if (frame_req) begin
            r_cmd_valid <= 1'b1;
            r_cmd_read  <= 1'b0;
            r_cmd_addr  <= 7'h04;
            r_cmd_data  <= w_vol;
            r_state     <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (frame_req) begin
            r_cmd_valid <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_addr  <= 7'h00;
            r_cmd_data  <= 16'h0000;
            r_to_cnt    <= r_to_cnt + TO_W'(1);
          end
          // A matching status is checked before the timeout, so a match in
          // the timeout frame still returns good data.
          if (w_match) begin
            r_rd_resp_valid <= 1'b1;
            r_rd_resp_data  <= status_data;
            r_rd_resp_err   <= 1'b0;
            r_state         <= S_IDLE;
          end else if (frame_req && (r_to_cnt == TO_W'(RD_TIMEOUT_FRAMES - 1))) begin
            r_rd_resp_valid <= 1'b1;
            r_rd_resp_data  <= 16'hFFFF;
            r_rd_resp_err   <= 1'b1;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_read      = r_cmd_read;
  assign cmd_addr      = r_cmd_addr;
  assign cmd_data      = r_cmd_data;
  assign cpu_req_ready = w_cpu_accept;
  assign rd_resp_valid = r_rd_resp_valid;
  assign rd_resp_data  = r_rd_resp_data;
  assign rd_resp_err   = r_rd_resp_err;
  assign init_done     = r_init_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_ac97_cmd_scheduler.sv
// Testbench for ac97_cmd_scheduler. A vector table covers the init sequence
// and the basic CPU writes and idle frames. Hand-written sequences cover
// reads, timeouts, the match/timeout tie, and reset during a read. When
// AC97_VOL_TRACK_EN is defined, they also cover volume-change refresh.
module tb_ac97_cmd_scheduler;

  logic        bit_clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        frame_req = 1'b0;
  logic        cmd_valid, cmd_read;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cpu_req_valid = 1'b0, cpu_req_rd = 1'b0;
  logic [6:0]  cpu_req_addr = 7'h00;
  logic [15:0] cpu_req_data = 16'h0000;
  logic        cpu_req_ready;
  logic        status_valid = 1'b0;
  logic [6:0]  status_addr = 7'h00;
  logic [15:0] status_data = 16'h0000;
  logic        rd_resp_valid, rd_resp_err;
  logic [15:0] rd_resp_data;
  logic [3:0]  volume_control = 4'h5;
  logic        init_done;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int resp_cnt = 0;

  ac97_cmd_scheduler dut (
    .bit_clk(bit_clk), .reset_b(reset_b), .frame_req(frame_req),
    .cmd_valid(cmd_valid), .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rd(cpu_req_rd), .cpu_req_addr(cpu_req_addr),
    .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready),
    .status_valid(status_valid), .status_addr(status_addr), .status_data(status_data),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .volume_control(volume_control), .init_done(init_done), .dbg_state(dbg_state)
  );

  // clock
  always #5 bit_clk = ~bit_clk;

  // count read-response pulses
  always @(negedge bit_clk) if (rd_resp_valid) resp_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        c_v;
    logic        c_rd;
    logic [6:0]  c_a;
    logic [15:0] c_d;
    logic [3:0]  vc;
    logic        e_rdy;
    logic        e_v;
    logic        e_rd;
    logic [6:0]  e_a;
    logic [15:0] e_d;
    logic        e_done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_cmd(input string nm, input logic v, input logic rd,
                           input logic [6:0] a, input logic [15:0] d);
    check(nm, {7'd0, cmd_valid, cmd_read, cmd_addr, cmd_data}, {7'd0, v, rd, a, d});
  endtask

  // One frame: drive the CPU fields and frame_req for one cycle, and sample
  // ready while frame_req is high. On return (next negedge) the new command
  // is visible.
  task automatic do_frame(input logic c_v, input logic c_rd, input logic [6:0] c_a,
                          input logic [15:0] c_d, input logic [3:0] vc, output logic rdy);
    @(negedge bit_clk);
    cpu_req_valid  = c_v;
    cpu_req_rd     = c_rd;
    cpu_req_addr   = c_a;
    cpu_req_data   = c_d;
    volume_control = vc;
    frame_req      = 1'b1;
    #1 rdy = cpu_req_ready;
    @(negedge bit_clk);
    frame_req = 1'b0;
    #1;
  endtask

  task automatic status_pulse(input logic [6:0] a, input logic [15:0] d);
    @(negedge bit_clk);
    status_valid = 1'b1;
    status_addr  = a;
    status_data  = d;
    @(negedge bit_clk);
    status_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic rdy;
    int base;

    vecs[0] = '{1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, 1'b0, 1'b1, 1'b0, 7'h02, 16'h1515, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, 1'b0, 1'b1, 1'b0, 7'h04, 16'h1515, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 7'h18, 16'h0A0A, 4'h5, 1'b0, 1'b1, 1'b0, 7'h18, 16'h0808, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 7'h18, 16'h0A0A, 4'h5, 1'b0, 1'b1, 1'b0, 7'h0E, 16'h0008, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 7'h18, 16'h0A0A, 4'h5, 1'b0, 1'b1, 1'b0, 7'h1A, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 7'h18, 16'h0A0A, 4'h5, 1'b0, 1'b1, 1'b0, 7'h1C, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 7'h18, 16'h0A0A, 4'h5, 1'b1, 1'b1, 1'b0, 7'h18, 16'h0A0A, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 7'h2C, 16'hBEEF, 4'h5, 1'b1, 1'b1, 1'b0, 7'h2C, 16'hBEEF, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b1};

    // reset state
    repeat (3) @(negedge bit_clk);
    #1;
    check_cmd("reset_cmd", 1'b0, 1'b0, 7'h00, 16'h0000);
    check("reset_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("reset_resp", {15'd0, rd_resp_valid, rd_resp_data}, 32'd0);
    check("reset_done", {31'd0, init_done}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge bit_clk);
    reset_b = 1'b1;

    // init table, CPU write, idle frames
    for (int i = 0; i < 10; i++) begin
      do_frame(vecs[i].c_v, vecs[i].c_rd, vecs[i].c_a, vecs[i].c_d, vecs[i].vc, rdy);
      check($sformatf("v%0d_ready", i), {31'd0, rdy}, {31'd0, vecs[i].e_rdy});
      check_cmd($sformatf("v%0d_cmd", i), vecs[i].e_v, vecs[i].e_rd, vecs[i].e_a, vecs[i].e_d);
      check($sformatf("v%0d_done", i), {31'd0, init_done}, {31'd0, vecs[i].e_done});
    end

    // CPU read answered by status; CPU held off while waiting
    do_frame(1'b1, 1'b1, 7'h26, 16'h5555, 4'h5, rdy);
    check("rd26_ready", {31'd0, rdy}, 32'd1);
    check_cmd("rd26_cmd", 1'b1, 1'b1, 7'h26, 16'h0000);
    base = resp_cnt;
    do_frame(1'b1, 1'b0, 7'h10, 16'h1111, 4'h5, rdy);
    check("rdwait1_ready", {31'd0, rdy}, 32'd0);
    check_cmd("rdwait1_cmd", 1'b0, 1'b0, 7'h00, 16'h0000);
    check("rdwait_state", {30'd0, dbg_state}, 32'd2);
    do_frame(1'b1, 1'b0, 7'h10, 16'h1111, 4'h5, rdy);
    check("rdwait2_ready", {31'd0, rdy}, 32'd0);
    status_pulse(7'h25, 16'hAAAA);
    check("nomatch_resp", {31'd0, rd_resp_valid}, 32'd0);
    status_pulse(7'h26, 16'h000F);
    check("rd26_resp", {14'd0, rd_resp_valid, rd_resp_err, rd_resp_data}, {14'd0, 1'b1, 1'b0, 16'h000F});
    @(negedge bit_clk);
    #1;
    check("rd26_pulse_end", {31'd0, rd_resp_valid}, 32'd0);
    check("rd26_count", resp_cnt - base, 32'd1);
    do_frame(1'b1, 1'b0, 7'h10, 16'h1111, 4'h5, rdy);
    check("after_rd_ready", {31'd0, rdy}, 32'd1);
    check_cmd("after_rd_cmd", 1'b1, 1'b0, 7'h10, 16'h1111);

    // CPU read with no status: timeout after four frames
    do_frame(1'b1, 1'b1, 7'h7C, 16'h0000, 4'h5, rdy);
    check("rd7c_ready", {31'd0, rdy}, 32'd1);
    base = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, rdy);
      check($sformatf("to_wait%0d", i), resp_cnt - base, 32'd0);
    end
    do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, rdy);
    check("to_resp", {14'd0, rd_resp_valid, rd_resp_err, rd_resp_data}, {14'd0, 1'b1, 1'b1, 16'hFFFF});
    check("to_state", {30'd0, dbg_state}, 32'd1);
    do_frame(1'b1, 1'b0, 7'h3A, 16'h00C3, 4'h5, rdy);
    check("to_next_ready", {31'd0, rdy}, 32'd1);
    check_cmd("to_next_cmd", 1'b1, 1'b0, 7'h3A, 16'h00C3);

    // match arriving with the timeout frame_req wins
    do_frame(1'b1, 1'b1, 7'h33, 16'h0000, 4'h5, rdy);
    base = resp_cnt;
    for (int i = 0; i < 3; i++) do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, rdy);
    @(negedge bit_clk);
    frame_req    = 1'b1;
    status_valid = 1'b1;
    status_addr  = 7'h33;
    status_data  = 16'h0123;
    @(negedge bit_clk);
    frame_req    = 1'b0;
    status_valid = 1'b0;
    #1;
    check("tie_resp", {14'd0, rd_resp_valid, rd_resp_err, rd_resp_data}, {14'd0, 1'b1, 1'b0, 16'h0123});
    @(negedge bit_clk);
    #1;
    check("tie_count", resp_cnt - base, 32'd1);
    check("tie_state", {30'd0, dbg_state}, 32'd1);

    // reset during RD_WAIT drops the read
    do_frame(1'b1, 1'b1, 7'h40, 16'h0000, 4'h5, rdy);
    do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, rdy);
    base = resp_cnt;
    @(negedge bit_clk);
    reset_b = 1'b0;
    #1;
    check_cmd("midrst_cmd", 1'b0, 1'b0, 7'h00, 16'h0000);
    check("midrst_done", {31'd0, init_done}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge bit_clk);
    reset_b = 1'b1;
    status_pulse(7'h40, 16'h1234);
    repeat (2) @(negedge bit_clk);
    check("midrst_noresp", resp_cnt - base, 32'd0);
    do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, rdy);
    check_cmd("midrst_first", 1'b1, 1'b0, 7'h02, 16'h1515);
    for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b0, 7'h00, 16'h0000, 4'h5, rdy);
    check_cmd("reinit_last", 1'b1, 1'b0, 7'h1C, 16'h0000);
    check("reinit_done", {31'd0, init_done}, 32'd1);

`ifdef AC97_VOL_TRACK_EN
    // volume change while a CPU request waits: refresh first
    @(negedge bit_clk);
    volume_control = 4'hA;
    cpu_req_valid  = 1'b1;
    cpu_req_rd     = 1'b0;
    cpu_req_addr   = 7'h20;
    cpu_req_data   = 16'h2222;
    do_frame(1'b1, 1'b0, 7'h20, 16'h2222, 4'hA, rdy);
    check("vt_ref1_ready", {31'd0, rdy}, 32'd0);
    check_cmd("vt_ref1_cmd", 1'b1, 1'b0, 7'h02, 16'h1A1A);
    do_frame(1'b1, 1'b0, 7'h20, 16'h2222, 4'hA, rdy);
    check("vt_ref2_ready", {31'd0, rdy}, 32'd0);
    check_cmd("vt_ref2_cmd", 1'b1, 1'b0, 7'h04, 16'h1A1A);
    do_frame(1'b1, 1'b0, 7'h20, 16'h2222, 4'hA, rdy);
    check("vt_cpu_ready", {31'd0, rdy}, 32'd1);
    check_cmd("vt_cpu_cmd", 1'b1, 1'b0, 7'h20, 16'h2222);
    cpu_req_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac97_cmd_scheduler.md
AC97_CMD_SCHEDULER -- requirements
Module: ac97_cmd_scheduler

Interface
REQ-001 SHALL have parameters: INIT_LEN, 6, number of init-table entries; REFRESH_FRAMES, 64, frames between volume refresh writes; RD_TIMEOUT_FRAMES, 4, frames to wait for read status.
REQ-002 SHALL have ports, clock and reset first:
- bit_clk, in, 1, sole clock, codec bit clock.
- reset_b, in, 1, asynchronous active-low reset.
- frame_req, in, 1, one-cycle pulse from the frame engine; latch the next command.
- cmd_valid, out, 1, slot-1/2 command present for this frame.
- cmd_read, out, 1, slot-1 read bit.
- cmd_addr, out, 7, codec register index.
- cmd_data, out, 16, slot-2 write data.
- cpu_req_valid, in, 1, CPU register request pending.
- cpu_req_rd, in, 1, 1=read, 0=write.
- cpu_req_addr, in, 7, CPU register index.
- cpu_req_data, in, 16, CPU write data.
- cpu_req_ready, out, 1, request accepted this cycle.
- status_valid, in, 1, codec slot-1/2 status decoded.
- status_addr, in, 7, returned register index.
- status_data, in, 16, returned register data.
- rd_resp_valid, out, 1, read-response pulse.
- rd_resp_data, out, 16, read data.
- rd_resp_err, out, 1, read timed out.
- volume_control, in, 4, attenuation switch value.
- init_done, out, 1, init table fully issued.

Function
REQ-003 SHALL be an FSM with states INIT, IDLE, RD_WAIT, REFRESH; all decisions are taken only in a cycle with frame_req=1; cmd_* update on the next bit_clk edge (latency 1) and hold until the next frame_req.
REQ-004 INIT SHALL issue one write per frame_req, in order: 02h←VOL, 04h←VOL, 18h←0808h, 0Eh←0008h, 1Ah←0000h, 1Ch←0000h; VOL={3'b000,1'b1,vc,3'b000,1'b1,vc} with vc=volume_control sampled at that frame_req.
REQ-005 After the 6th INIT write is latched SHALL set init_done=1 and enter IDLE; cpu_req_ready SHALL remain 0 throughout INIT.
REQ-006 Priority in IDLE at frame_req: pending REFRESH > CPU request > idle frame (cmd_valid=0, cmd_read=0, cmd_addr=0, cmd_data=0).
REQ-007 CPU accept: cpu_req_ready SHALL be a one-cycle pulse coincident with the frame_req that selects the CPU; cmd_addr/cmd_data/cmd_read SHALL copy cpu_req_*; CPU SHALL hold request fields stable until ready.
REQ-008 A CPU read SHALL drive cmd_read=1, cmd_data=0000h and enter RD_WAIT; a CPU write returns to IDLE.
REQ-009 In RD_WAIT cmd_valid SHALL be 0 and no CPU request SHALL be accepted; status_valid with status_addr==latched address SHALL produce rd_resp_valid=1 for one cycle, rd_resp_data=status_data, rd_resp_err=0, then return to IDLE; non-matching status SHALL be ignored.
REQ-010 If RD_TIMEOUT_FRAMES frame_req pulses elapse in RD_WAIT without a match SHALL pulse rd_resp_valid with rd_resp_data=FFFFh, rd_resp_err=1 and return to IDLE; a match on the same cycle as the timeout frame_req SHALL win (err=0).
REQ-011 REFRESH SHALL issue 02h←VOL then 04h←VOL on two consecutive frame_req, then return to IDLE; a refresh request arising during RD_WAIT SHALL stay pending until RD_WAIT exits.
REQ-012 Refresh frame counter SHALL count frame_req in all states except INIT, wrap at REFRESH_FRAMES-1, and set the refresh pending flag on wrap; a second trigger while pending SHALL merge into one refresh.

Reset
REQ-013 reset_b=0 SHALL immediately force state INIT, table index 0, all counters 0, pending flags 0, and outputs cmd_*=0, cpu_req_ready=0, rd_resp_*=0, init_done=0; assertion mid-read SHALL drop the outstanding read with no response.
REQ-014 After reset release the first frame_req SHALL issue init entry 0.

Configuration
REQ-015 Macro AC97_VOL_TRACK_EN defined: volume_control registered each cycle; any change sets refresh pending in addition to REQ-012.
REQ-016 Macro AC97_VOL_TRACK_EN undefined: no change detection, no refresh counter, REFRESH state unreachable; volume written only during INIT.

Verification
REQ-017 Reset release, volume_control=5, 6 frame_req -> commands 02h/1515h, 04h/1515h, 18h/0808h, 0Eh/0008h, 1Ah/0000h, 1Ch/0000h; init_done=1 after the 6th.
REQ-018 After init, CPU write 18h/0A0Ah held valid -> cpu_req_ready pulses on next frame_req; next frame cmd_addr=18h, cmd_data=0A0Ah, cmd_read=0.
REQ-019 CPU read 26h, status 26h/000Fh two frames later -> rd_resp_valid one cycle, data 000Fh, err=0; CPU not accepted while waiting.
REQ-020 CPU read 7Ch, no status for 4 frame_req -> rd_resp_valid, data FFFFh, err=1, then IDLE.
REQ-021 With AC97_VOL_TRACK_EN, volume_control 5→A while CPU request pending -> next two frames 02h/1A1Ah, 04h/1A1Ah, then CPU request accepted.
REQ-022 reset_b low during RD_WAIT -> no rd_resp_valid; the first frame_req after release issues 02h.
